// File: rtl/collision_engine.sv
// collision_engine
//   Multi-slot bounding-box collision unit. A table of NUM_SLOTS boxes is
//   scanned against one query box, either stopping at the first hit (ANY)
//   or covering every slot (MASK). stall_req holds the issuing instruction
//   in EX while the scan runs.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   wr_en/wr_slot/wr_box/wr_valid  slot table write (wr_valid=0 retires)
//   clear_all       invalidate every slot (wins over wr_en)
//   start/mode/query_box  begin a query (mode 0=ANY, 1=MASK), idle only
//   busy, stall_req scan in progress
//   done            one-cycle result-ready pulse
//   hit/hit_index/hit_mask  result, held until the next accepted start
module collision_engine #(
    parameter  int COORD_WIDTH = 8,
    parameter  int NUM_SLOTS   = 8,
    localparam int SLOT_W      = $clog2(NUM_SLOTS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [SLOT_W-1:0]        wr_slot,
    input  logic [4*COORD_WIDTH-1:0] wr_box,
    input  logic                     wr_valid,
    input  logic                     clear_all,
    input  logic                     start,
    input  logic                     mode,
    input  logic [4*COORD_WIDTH-1:0] query_box,
    output logic                     busy,
    output logic                     stall_req,
    output logic                     done,
    output logic                     hit,
    output logic [SLOT_W-1:0]        hit_index,
    output logic [NUM_SLOTS-1:0]     hit_mask
);

    localparam int                BOX_W = 4 * COORD_WIDTH;
    localparam logic [SLOT_W-1:0] LAST  = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_next;

    logic [BOX_W-1:0]     slot_box [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;

    logic [BOX_W-1:0]  q_box;
    logic              q_mode;

    // Read stage: slot rd_idx is sampled from the table at the edge closing
    // its evaluation cycle, so a same-cycle write to it is not seen.
    logic [SLOT_W-1:0] rd_idx;
    logic              rd_done;

    // Compare stage: the sampled slot is tested one cycle later.
    logic              p_valid;
    logic              p_ok;
    logic [BOX_W-1:0]  p_box;
    logic [SLOT_W-1:0] p_idx;

    logic cmp_hit;
    logic scan_end;

    // Fields are widened by one bit so x+w cannot wrap. Zero-area boxes are
    // excluded explicitly: the strict inequalities alone would let a
    // zero-width box lying inside another one register a hit.
    function automatic logic boxes_overlap(input logic [BOX_W-1:0] a,
                                           input logic [BOX_W-1:0] b);
        logic [COORD_WIDTH:0] ax, ay, aw, ah, bx, by, bw, bh;
        ax = {1'b0, a[BOX_W-1       -: COORD_WIDTH]};
        ay = {1'b0, a[3*COORD_WIDTH-1 -: COORD_WIDTH]};
        aw = {1'b0, a[2*COORD_WIDTH-1 -: COORD_WIDTH]};
        ah = {1'b0, a[COORD_WIDTH-1   -: COORD_WIDTH]};
        bx = {1'b0, b[BOX_W-1       -: COORD_WIDTH]};
        by = {1'b0, b[3*COORD_WIDTH-1 -: COORD_WIDTH]};
        bw = {1'b0, b[2*COORD_WIDTH-1 -: COORD_WIDTH]};
        bh = {1'b0, b[COORD_WIDTH-1   -: COORD_WIDTH]};
        if (aw == '0 || ah == '0 || bw == '0 || bh == '0)
            return 1'b0;
        return (ax < bx + bw) && (bx < ax + aw) &&
               (ay < by + bh) && (by < ay + ah);
    endfunction

    assign busy      = (state == SCAN);
    assign stall_req = busy;
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        cmp_hit    = p_valid && p_ok && boxes_overlap(q_box, p_box);
        scan_end   = p_valid && ((!q_mode && cmp_hit) || (p_idx == LAST));
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = SCAN;
            SCAN:    if (scan_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slot table: writable in every state; clear_all takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            for (int unsigned s = 0; s < NUM_SLOTS; s++)
                slot_box[s] <= '0;
        end else if (clear_all) begin
            slot_valid <= '0;
        end else if (wr_en) begin
            slot_box[wr_slot]   <= wr_box;
            slot_valid[wr_slot] <= wr_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_box     <= '0;
            q_mode    <= 1'b0;
            rd_idx    <= '0;
            rd_done   <= 1'b0;
            p_valid   <= 1'b0;
            p_ok      <= 1'b0;
            p_box     <= '0;
            p_idx     <= '0;
            hit       <= 1'b0;
            hit_index <= '0;
            hit_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_box     <= query_box;
                        q_mode    <= mode;
                        rd_idx    <= '0;
                        rd_done   <= 1'b0;
                        p_valid   <= 1'b0;
                        hit       <= 1'b0;
                        hit_index <= '0;
                        hit_mask  <= '0;
                    end
                end
                SCAN: begin
                    if (!rd_done) begin
                        p_valid <= 1'b1;
                        p_ok    <= slot_valid[rd_idx];
                        p_box   <= slot_box[rd_idx];
                        p_idx   <= rd_idx;
                        if (rd_idx == LAST)
                            rd_done <= 1'b1;
                        else
                            rd_idx <= rd_idx + 1'b1;
                    end else begin
                        p_valid <= 1'b0;
                    end
                    if (cmp_hit) begin
                        hit_mask[p_idx] <= 1'b1;
                        if (!hit) begin
                            hit       <= 1'b1;
                            hit_index <= p_idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
